// File: rtl/uncached_handler.sv
// Uncached LSU path sequencer: arbitrates committed stores and uncached loads onto one
// SRAM-like bus port, one transaction at a time, with byte-lane formatting and load extension.
module uncached_handler #(
    parameter int unsigned ID_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_w,
    input  logic [31:0]     wb_addr,
    input  logic [31:0]     wb_data,
    input  logic [1:0]      wb_size,
    output logic            wb_ready,
    input  logic            ld_req,
    input  logic [31:0]     ld_addr,
    input  logic [1:0]      ld_size,
    input  logic            ld_signed,
    input  logic [ID_W-1:0] ld_id,
    output logic            ld_accept,
    input  logic            ld_flush,
    output logic            ld_valid,
    output logic [ID_W-1:0] ld_rid,
    output logic [31:0]     ld_rdata,
    output logic            bus_req,
    output logic            bus_wr,
    output logic [1:0]      bus_size,
    output logic [31:0]     bus_addr,
    output logic [31:0]     bus_wdata,
    output logic [3:0]      bus_wstrb,
    input  logic            bus_addr_ok,
    input  logic            bus_data_ok,
    input  logic [31:0]     bus_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_ADDR = 3'd1,
        W_DATA = 3'd2,
        R_ADDR = 3'd3,
        R_DATA = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              signed_q, signed_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              kill_q, kill_d;
    logic              ld_valid_q, ld_valid_d;
    logic [ID_W-1:0]   ld_rid_q, ld_rid_d;
    logic [31:0]       ld_rdata_q, ld_rdata_d;

    logic [3:0]        fmt_strb;
    logic [31:0]       fmt_data;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       rd_ext;

    // Store lane formatting from the incoming write-buffer head
    always_comb begin
        fmt_strb = 4'b1111;
        fmt_data = wb_data;
        case (wb_size)
            2'd0: begin
                fmt_strb = 4'b0001 << wb_addr[1:0];
                fmt_data = {4{wb_data[7:0]}};
            end
            2'd1: begin
                fmt_strb = wb_addr[1] ? 4'b1100 : 4'b0011;
                fmt_data = {2{wb_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane extraction and zero/sign extension using the latched request
    always_comb begin
        rd_byte = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
        rd_half = bus_rdata[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'd0:    rd_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
            2'd1:    rd_ext = {{16{signed_q & rd_half[15]}}, rd_half};
            default: rd_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        signed_d   = signed_q;
        id_d       = id_q;
        kill_d     = kill_q;
        ld_valid_d = 1'b0;
        ld_rid_d   = ld_rid_q;
        ld_rdata_d = ld_rdata_q;
        wb_ready   = 1'b0;
        ld_accept  = 1'b0;
        bus_req    = 1'b0;
        bus_wr     = 1'b0;
        case (state_q)
            IDLE: begin
                // Stores win so older uncached stores drain ahead of later loads
                if (wb_w) begin
                    addr_d  = wb_addr;
                    size_d  = wb_size;
                    wdata_d = fmt_data;
                    wstrb_d = fmt_strb;
                    state_d = W_ADDR;
                end else if (ld_req && !ld_flush) begin
                    ld_accept = 1'b1;
                    addr_d    = ld_addr;
                    size_d    = ld_size;
                    signed_d  = ld_signed;
                    id_d      = ld_id;
                    wstrb_d   = 4'b0000;
                    kill_d    = 1'b0;
                    state_d   = R_ADDR;
                end
            end
            W_ADDR: begin
                bus_req = 1'b1;
                bus_wr  = 1'b1;
                if (bus_addr_ok) state_d = W_DATA;
            end
            W_DATA: begin
                bus_wr = 1'b1;
                if (bus_data_ok) begin
                    wb_ready = 1'b1;
                    state_d  = IDLE;
                end
            end
            R_ADDR: begin
                bus_req = 1'b1;
                if (ld_flush)    kill_d  = 1'b1;
                if (bus_addr_ok) state_d = R_DATA;
            end
            R_DATA: begin
                if (ld_flush) kill_d = 1'b1;
                if (bus_data_ok) begin
                    state_d = IDLE;
                    // A flush arriving with the data still kills the response
                    if (!kill_q && !ld_flush) begin
                        ld_valid_d = 1'b1;
                        ld_rid_d   = id_q;
                        ld_rdata_d = rd_ext;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            signed_q   <= 1'b0;
            id_q       <= '0;
            kill_q     <= 1'b0;
            ld_valid_q <= 1'b0;
            ld_rid_q   <= '0;
            ld_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            signed_q   <= signed_d;
            id_q       <= id_d;
            kill_q     <= kill_d;
            ld_valid_q <= ld_valid_d;
            ld_rid_q   <= ld_rid_d;
            ld_rdata_q <= ld_rdata_d;
        end
    end

    assign bus_addr  = addr_q;
    assign bus_size  = size_q;
    assign bus_wdata = wdata_q;
    assign bus_wstrb = wstrb_q;
    assign ld_valid  = ld_valid_q;
    assign ld_rid    = ld_rid_q;
    assign ld_rdata  = ld_rdata_q;

endmodule
